// File: rtl/bin2bcd_seq_if.sv
// Handshake/data bundle for the sequential binary-to-BCD converter.
//   init : start request, level-sampled by the converter
//   bin  : binary value to convert (WIDTH bits)
//   bcd  : converted decimal digits, bcd[3:0] = units (4*DIGITS bits)
//   sign : 1 = last converted value was negative (signed build only)
//   busy : conversion in progress
//   done : one-cycle pulse when bcd/sign update
// master = requester (drives init/bin), slave = converter.
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2
);
    logic                  init;
    logic [WIDTH-1:0]      bin;
    logic [4*DIGITS-1:0]   bcd;
    logic                  sign;
    logic                  busy;
    logic                  done;

    modport master (output init, output bin, input bcd, input sign, input busy, input done);
    modport slave  (input init, input bin, output bcd, output sign, output busy, output done);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3 / double dabble).
// Takes WIDTH SHIFT cycles per conversion plus one DONE cycle; a new start
// is accepted in IDLE or DONE, so back-to-back requests complete every
// WIDTH+1 cycles. In the signed build the magnitude is converted and the
// sign is reported separately.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous reset, active low
//   bus : bin2bcd_seq_if.slave (init, bin in; bcd, sign, busy, done out)
module bin2bcd_seq #(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    bin2bcd_seq_if.slave     bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = 4 * DIGITS;

    // Every WIDTH-bit value must fit in DIGITS decimal digits.
    generate
        if (10 ** DIGITS <= 2 ** WIDTH - 1) begin : g_bad_digits
            $error("bin2bcd_seq: DIGITS too small for WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [SW-1:0]    scratch_reg, scratch_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             pend_sign_reg, pend_sign_next;
    logic [SW-1:0]    bcd_reg, bcd_next;
    logic             sign_reg, sign_next;

    // Value loaded at start: magnitude plus pending sign.
    logic [WIDTH-1:0] load_val;
    logic             load_neg;

    generate
        if (SIGNED != 0) begin : g_signed
            assign load_neg = bus.bin[WIDTH-1];
            // The most negative input negates to itself, which read as
            // unsigned is exactly the wanted magnitude.
            assign load_val = load_neg ? (~bus.bin + WIDTH'(1)) : bus.bin;
        end else begin : g_unsigned
            assign load_neg = 1'b0;
            assign load_val = bus.bin;
        end
    endgenerate

    // Add-3 correction on every digit, including the top one.
    logic [SW-1:0] adj;
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
            assign adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                                    ? scratch_reg[4*gi +: 4] + 4'd3
                                    : scratch_reg[4*gi +: 4];
        end
    endgenerate

    logic [SW+WIDTH-1:0] shifted;
    assign shifted = {adj[SW-2:0], shift_reg, 1'b0};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            scratch_reg   <= '0;
            count_reg     <= '0;
            pend_sign_reg <= 1'b0;
            bcd_reg       <= '0;
            sign_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shift_reg     <= shift_next;
            scratch_reg   <= scratch_next;
            count_reg     <= count_next;
            pend_sign_reg <= pend_sign_next;
            bcd_reg       <= bcd_next;
            sign_reg      <= sign_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        scratch_next   = scratch_reg;
        count_next     = count_reg;
        pend_sign_next = pend_sign_reg;
        bcd_next       = bcd_reg;
        sign_next      = sign_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (bus.init) begin
                    shift_next     = load_val;
                    pend_sign_next = load_neg;
                    scratch_next   = '0;
                    count_next     = CW'(WIDTH);
                    state_next     = SHIFT;
                end else begin
                    state_next     = IDLE;
                end
            end
            SHIFT: begin
                scratch_next = shifted[SW+WIDTH-1:WIDTH];
                shift_next   = shifted[WIDTH-1:0];
                count_next   = count_reg - CW'(1);
                // Publish only the finished result so bcd never shows a
                // partial conversion.
                if (count_reg == CW'(1)) begin
                    bcd_next   = shifted[SW+WIDTH-1:WIDTH];
                    sign_next  = pend_sign_reg;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy = (state_reg == SHIFT);
    assign bus.done = (state_reg == DONE);
    assign bus.bcd  = bcd_reg;
    assign bus.sign = sign_reg;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: an unsigned and a signed instance are driven with
// identical stimulus and compared against a decimal reference model.
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    bin2bcd_seq_if #(.WIDTH(6), .DIGITS(2)) u_if ();
    bin2bcd_seq_if #(.WIDTH(6), .DIGITS(2)) s_if ();

    bin2bcd_seq #(.WIDTH(6), .DIGITS(2), .SIGNED(0)) dut_u (.clk(clk), .rst(rst), .bus(u_if));
    bin2bcd_seq #(.WIDTH(6), .DIGITS(2), .SIGNED(1)) dut_s (.clk(clk), .rst(rst), .bus(s_if));

    typedef struct {
        int         lat;        // edges from init edge to first done, -1 = none
        int         busy_cnt;
        int         done_cnt;
        bit         held_changed;
        logic [7:0] bcd0;
        logic [7:0] bcd;
        logic       sign;
    } obs_t;

    // Reference model: plain decimal arithmetic.
    function automatic logic [7:0] dec2bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int smag(input logic [5:0] b);
        return b[5] ? 64 - int'(b) : int'(b);
    endfunction

    function automatic void observe(inout obs_t o, input int k, input logic d,
                                    input logic b, input logic [7:0] c, input logic s);
        if (b) o.busy_cnt++;
        if (d) begin
            o.done_cnt++;
            if (o.lat < 0) begin
                o.lat  = k - 1;
                o.bcd  = c;
                o.sign = s;
            end
        end
        if (o.lat < 0 && c !== o.bcd0) o.held_changed = 1'b1;
    endfunction

    task automatic drive(input logic i, input logic [5:0] b);
        u_if.init = i; u_if.bin = b;
        s_if.init = i; s_if.bin = b;
    endtask

    // One init pulse, then an 8-cycle observation window (bounded).
    task automatic run_one(input logic [5:0] val, output obs_t ou, output obs_t os);
        ou.lat = -1; ou.busy_cnt = 0; ou.done_cnt = 0; ou.held_changed = 0;
        ou.bcd = 'x; ou.sign = 'x;
        os = ou;
        @(negedge clk);
        ou.bcd0 = u_if.bcd;
        os.bcd0 = s_if.bcd;
        drive(1'b1, val);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            observe(ou, k, u_if.done, u_if.busy, u_if.bcd, u_if.sign);
            observe(os, k, s_if.done, s_if.busy, s_if.bcd, s_if.sign);
            // Scramble bin after the start edge; it must not matter.
            if (k == 1) drive(1'b0, 6'($urandom));
        end
        $display("conv bin=%0d u_bcd=%h u_lat=%0d s_bcd=%h s_sign=%0b",
                 val, ou.bcd, ou.lat, os.bcd, os.sign);
    endtask

    task automatic test_reset();
        drive(1'b0, 6'd0);
        repeat (3) @(negedge clk);
        n_vec++; if (u_if.bcd !== 8'h00) begin n_err++; $display("FAIL reset_u_bcd got=%h exp=00", u_if.bcd); end
        n_vec++; if (u_if.busy !== 1'b0) begin n_err++; $display("FAIL reset_u_busy got=%b exp=0", u_if.busy); end
        n_vec++; if (u_if.done !== 1'b0) begin n_err++; $display("FAIL reset_u_done got=%b exp=0", u_if.done); end
        n_vec++; if (u_if.sign !== 1'b0) begin n_err++; $display("FAIL reset_u_sign got=%b exp=0", u_if.sign); end
        n_vec++; if (s_if.bcd !== 8'h00) begin n_err++; $display("FAIL reset_s_bcd got=%h exp=00", s_if.bcd); end
        n_vec++; if (s_if.sign !== 1'b0) begin n_err++; $display("FAIL reset_s_sign got=%b exp=0", s_if.sign); end
        rst = 1'b1;
        $display("reset released");
    endtask

    task automatic test_max();
        obs_t ou, os;
        run_one(6'd63, ou, os);
        n_vec++; if (ou.lat !== 6) begin n_err++; $display("FAIL max_latency got=%0d exp=6", ou.lat); end
        n_vec++; if (ou.busy_cnt !== 6) begin n_err++; $display("FAIL max_busy_cycles got=%0d exp=6", ou.busy_cnt); end
        n_vec++; if (ou.done_cnt !== 1) begin n_err++; $display("FAIL max_done_count got=%0d exp=1", ou.done_cnt); end
        n_vec++; if (ou.bcd !== 8'h63) begin n_err++; $display("FAIL max_bcd got=%h exp=63", ou.bcd); end
        n_vec++; if (ou.sign !== 1'b0) begin n_err++; $display("FAIL max_sign got=%b exp=0", ou.sign); end
        n_vec++; if (os.bcd !== 8'h01) begin n_err++; $display("FAIL max_s_bcd got=%h exp=01", os.bcd); end
        n_vec++; if (os.sign !== 1'b1) begin n_err++; $display("FAIL max_s_sign got=%b exp=1", os.sign); end
    endtask

    task automatic test_zero_ten();
        obs_t ou, os;
        run_one(6'd0, ou, os);
        n_vec++; if (ou.bcd !== 8'h00) begin n_err++; $display("FAIL zero_bcd got=%h exp=00", ou.bcd); end
        n_vec++; if (ou.lat !== 6) begin n_err++; $display("FAIL zero_latency got=%0d exp=6", ou.lat); end
        n_vec++; if (os.sign !== 1'b0) begin n_err++; $display("FAIL zero_s_sign got=%b exp=0", os.sign); end
        run_one(6'd10, ou, os);
        n_vec++; if (ou.held_changed !== 1'b0) begin n_err++; $display("FAIL ten_bcd_held got=%b exp=0", ou.held_changed); end
        n_vec++; if (ou.bcd !== 8'h10) begin n_err++; $display("FAIL ten_bcd got=%h exp=10", ou.bcd); end
    endtask

    task automatic test_signed();
        logic [5:0] vals [3] = '{6'b111011, 6'b100000, 6'd31};
        logic [7:0] exp_b [3] = '{8'h05, 8'h32, 8'h31};
        logic       exp_s [3] = '{1'b1, 1'b1, 1'b0};
        obs_t ou, os;
        for (int i = 0; i < 3; i++) begin
            run_one(vals[i], ou, os);
            n_vec++; if (os.bcd !== exp_b[i]) begin n_err++; $display("FAIL signed_bcd bin=%b got=%h exp=%h", vals[i], os.bcd, exp_b[i]); end
            n_vec++; if (os.sign !== exp_s[i]) begin n_err++; $display("FAIL signed_sign bin=%b got=%b exp=%b", vals[i], os.sign, exp_s[i]); end
            n_vec++; if (os.lat !== 6) begin n_err++; $display("FAIL signed_latency got=%0d exp=6", os.lat); end
        end
    endtask

    task automatic test_back_to_back();
        int prev = -1;
        int ndone = 0;
        int cnt = 0;
        @(negedge clk);
        drive(1'b1, 6'd42);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (u_if.done) begin
                ndone++;
                n_vec++; if (u_if.bcd !== 8'h42) begin n_err++; $display("FAIL b2b_bcd got=%h exp=42", u_if.bcd); end
                if (prev >= 0) begin
                    n_vec++; if (k - prev !== 7) begin n_err++; $display("FAIL b2b_period got=%0d exp=7", k - prev); end
                end
                prev = k;
            end
        end
        n_vec++; if (ndone !== 4) begin n_err++; $display("FAIL b2b_done_count got=%0d exp=4", ndone); end
        drive(1'b0, 6'd0);
        repeat (10) @(negedge clk);

        // Re-pulse mid-SHIFT with a different value: must be ignored.
        drive(1'b1, 6'd42);
        prev = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (u_if.done) begin
                cnt++;
                if (prev < 0) prev = k - 1;
            end
            if (k == 1) drive(1'b0, 6'd42);
            if (k == 3) drive(1'b1, 6'd7);
            if (k == 4) drive(1'b0, 6'd7);
        end
        $display("repulse done_edges=%0d dones=%0d bcd=%h", prev, cnt, u_if.bcd);
        n_vec++; if (prev !== 6) begin n_err++; $display("FAIL repulse_latency got=%0d exp=6", prev); end
        n_vec++; if (cnt !== 1) begin n_err++; $display("FAIL repulse_done_count got=%0d exp=1", cnt); end
        n_vec++; if (u_if.bcd !== 8'h42) begin n_err++; $display("FAIL repulse_bcd got=%h exp=42", u_if.bcd); end
    endtask

    task automatic test_sweep();
        obs_t ou, os;
        for (int v = 0; v < 64; v++) begin
            run_one(6'(v), ou, os);
            n_vec++; if (ou.bcd !== dec2bcd(v)) begin n_err++; $display("FAIL sweep_bcd bin=%0d got=%h exp=%h", v, ou.bcd, dec2bcd(v)); end
            n_vec++; if (ou.done_cnt !== 1) begin n_err++; $display("FAIL sweep_done_count bin=%0d got=%0d exp=1", v, ou.done_cnt); end
            n_vec++; if (os.bcd !== dec2bcd(smag(6'(v)))) begin n_err++; $display("FAIL sweep_s_bcd bin=%0d got=%h exp=%h", v, os.bcd, dec2bcd(smag(6'(v)))); end
            n_vec++; if (os.sign !== (v >= 32)) begin n_err++; $display("FAIL sweep_s_sign bin=%0d got=%b exp=%b", v, os.sign, v >= 32); end
        end
    endtask

    task automatic test_random();
        obs_t ou, os;
        logic [5:0] v;
        for (int i = 0; i < 16; i++) begin
            v = 6'($urandom_range(0, 63));
            run_one(v, ou, os);
            n_vec++; if (ou.bcd !== dec2bcd(int'(v))) begin n_err++; $display("FAIL rand_bcd bin=%0d got=%h exp=%h", v, ou.bcd, dec2bcd(int'(v))); end
            n_vec++; if (ou.lat !== 6) begin n_err++; $display("FAIL rand_latency bin=%0d got=%0d exp=6", v, ou.lat); end
            n_vec++; if (os.bcd !== dec2bcd(smag(v))) begin n_err++; $display("FAIL rand_s_bcd bin=%0d got=%h exp=%h", v, os.bcd, dec2bcd(smag(v))); end
            n_vec++; if (os.sign !== v[5]) begin n_err++; $display("FAIL rand_s_sign bin=%0d got=%b exp=%b", v, os.sign, v[5]); end
        end
    endtask

    task automatic test_reset_mid();
        obs_t ou, os;
        int cnt = 0;
        run_one(6'd55, ou, os);
        @(negedge clk);
        drive(1'b1, 6'd37);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) drive(1'b0, 6'd37);
        end
        #1 rst = 1'b0;
        #1;
        $display("async reset mid-shift u_bcd=%h busy=%b done=%b", u_if.bcd, u_if.busy, u_if.done);
        n_vec++; if (u_if.bcd !== 8'h00) begin n_err++; $display("FAIL midrst_bcd got=%h exp=00", u_if.bcd); end
        n_vec++; if (u_if.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b exp=0", u_if.busy); end
        n_vec++; if (u_if.done !== 1'b0) begin n_err++; $display("FAIL midrst_done got=%b exp=0", u_if.done); end
        n_vec++; if (s_if.bcd !== 8'h00) begin n_err++; $display("FAIL midrst_s_bcd got=%h exp=00", s_if.bcd); end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (u_if.done || u_if.busy) cnt++;
        end
        n_vec++; if (cnt !== 0) begin n_err++; $display("FAIL midrst_aborted got=%0d exp=0", cnt); end
        run_one(6'd19, ou, os);
        n_vec++; if (ou.bcd !== 8'h19) begin n_err++; $display("FAIL midrst_after_bcd got=%h exp=19", ou.bcd); end
        n_vec++; if (ou.lat !== 6) begin n_err++; $display("FAIL midrst_after_latency got=%0d exp=6", ou.lat); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 6'd0);
        test_reset();
        test_max();
        test_zero_ten();
        test_signed();
        test_back_to_back();
        test_sweep();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
- Sits directly downstream of the ALU result register (sal_f). It converts the 6-bit operation result into decimal digits for the seven-segment display stage.
- Uses an init/done handshake in the same style as the arithmetic units (sum4b, Resta, multiplicador, Divisor).
- Optional signed mode supports subtraction results in two's complement.

Parameters:
- WIDTH, 6: binary input width in bits.
- DIGITS, 2: number of BCD output digits. Legal only when 10^DIGITS > 2^WIDTH − 1; with the defaults, 100 > 63.
- SIGNED, 0: 0 = bin is unsigned; 1 = bin is two's complement, and the magnitude is converted with the sign reported separately.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst  in  1  reset.
- init  in  1  start request, level-sampled.
- bin  in  WIDTH  binary value to convert.
- bcd  out  4*DIGITS  converted digits. bcd[3:0] is the units digit; higher nibbles hold higher decades.
- sign  out  1  1 = converted value was negative (SIGNED=1 only); tied 0 when SIGNED=0.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when bcd/sign update.

Interface (already decided):
- One clock; reset is asynchronous and active-low.
- Clock port is clk, reset port is rst; rst=0 resets.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; bcd=0, sign=0, busy=0, done=0.
  - Internal shift register and counter cleared.
- States:
  - IDLE: waiting for a request.
  - SHIFT: converting, for exactly WIDTH cycles.
  - DONE: single cycle with done=1.
- IDLE or DONE, init=1 at edge E0:
  - Capture bin into the shift register. If SIGNED=1 and bin[WIDTH-1]=1, load the magnitude (−bin, WIDTH bits, unsigned) and latch the pending sign as 1; otherwise load bin and latch the pending sign as 0.
  - Clear the BCD scratch register; count=WIDTH; go to SHIFT; busy=1.
- IDLE or DONE, init=0: go to / stay in IDLE; busy=0.
- SHIFT, each edge:
  - First, for each scratch digit ≥5, add 3 to that digit.
  - Then shift {scratch, shift register} left by 1.
  - Decrement count.
- SHIFT, edge where count goes 1→0 (edge E_WIDTH):
  - bcd ← final scratch value; sign ← pending sign; done=1; busy=0; go to DONE.
- DONE, next edge: done=0; a new start is accepted per the IDLE/DONE rules above.
- Timing:
  - done is high during the cycle following E_WIDTH, i.e. WIDTH edges after init is sampled.
  - Sustained throughput is one conversion per WIDTH+1 cycles.
- Boundary conditions:
  - init=1 while busy=1 is ignored; no queuing.
  - bin changes after E0 have no effect on the running conversion.
  - bcd/sign hold their last completed value until the next done; they are never partially updated.
  - SIGNED=1 with the most negative input (e.g. 6'b100000): magnitude is 32 as an unsigned value, bcd=0x32, sign=1.
  - Zero input: bcd=0, sign=0 (never negative zero).
  - Reset during SHIFT aborts the conversion: no done, and bcd returns to 0.
- Width rules:
  - Scratch register is 4*DIGITS bits; count is clog2(WIDTH+1) bits.
  - Add-3 correction is applied to every digit each cycle, including the most significant one.
  - Elaboration fails if the DIGITS legality rule is violated.

Test Plan:
- Default parameters, bin=6'd63, init=1 for one cycle: busy=1 for 6 cycles; done pulses once, 6 edges after the init edge; bcd=8'h63, sign=0.
- bin=0 → bcd=8'h00, done after 6 edges. Then bin=6'd10 → bcd=8'h10. Check bcd holds 8'h00 during the second conversion until done.
- SIGNED=1: bin=6'b111011 (−5) → bcd=8'h05, sign=1. bin=6'b100000 → bcd=8'h32, sign=1. bin=6'd31 → bcd=8'h31, sign=0.
- init held high continuously with bin=6'd42 → done every 7 cycles; bcd=8'h42 each time. A re-pulse of init mid-SHIFT, with bin changed to 6'd7, does not alter the result or timing.
- Sweep bin 0..63 (unsigned), one conversion each → bcd matches the decimal value for every input, with exactly one done per request.
- Assert rst=0 asynchronously at the 3rd SHIFT cycle → bcd=0, busy=0, done=0 immediately. After release, a new init with bin=6'd19 gives bcd=8'h19.
